multi_cycle_control_unit: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath (PC, ROM, RegFile, Extend, ALU, RAM, PCcounter).

---
 rtl/mcpu_pkg.sv | 63 ++++++
 rtl/op_class_decode.sv | 74 +++++++
 rtl/multi_cycle_control_unit.sv | 211 +++++++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Holds opcode and ALU function codes, FSM state encodings and the
// opcode classes produced by op_class_decode.
package mcpu_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpAdd   = 6'b000000;
  localparam logic [5:0] OpSub   = 6'b000001;
  localparam logic [5:0] OpAddiu = 6'b000010;
  localparam logic [5:0] OpAnd   = 6'b010000;
  localparam logic [5:0] OpAndi  = 6'b010001;
  localparam logic [5:0] OpOri   = 6'b010010;
  localparam logic [5:0] OpXori  = 6'b010011;
  localparam logic [5:0] OpSll   = 6'b011000;
  localparam logic [5:0] OpSlti  = 6'b100110;
  localparam logic [5:0] OpSw    = 6'b110000;
  localparam logic [5:0] OpLw    = 6'b110001;
  localparam logic [5:0] OpBeq   = 6'b110100;
  localparam logic [5:0] OpBne   = 6'b110101;
  localparam logic [5:0] OpBltz  = 6'b110110;
  localparam logic [5:0] OpJ     = 6'b111000;
  localparam logic [5:0] OpJr    = 6'b111001;
  localparam logic [5:0] OpJal   = 6'b111010;
  localparam logic [5:0] OpHalt  = 6'b111111;

  // ALU function codes
  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluSll  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluAnd  = 3'b100;
  localparam logic [2:0] AluSltu = 3'b101;
  localparam logic [2:0] AluSlt  = 3'b110;
  localparam logic [2:0] AluXor  = 3'b111;

  typedef enum logic [3:0] {
    StIf    = 4'd0,
    StId    = 4'd1,
    StExeAl = 4'd2,
    StWbAl  = 4'd3,
    StExeBr = 4'd4,
    StExeLs = 4'd5,
    StMem   = 4'd6,
    StWbLd  = 4'd7,
    StHalt  = 4'd8
  } state_e;

  // Branches are kept separate so EXE_BR can pick its taken condition.
  typedef enum logic [3:0] {
    ClsAlu     = 4'd0,
    ClsBeq     = 4'd1,
    ClsBne     = 4'd2,
    ClsBltz    = 4'd3,
    ClsSw      = 4'd4,
    ClsLw      = 4'd5,
    ClsJ       = 4'd6,
    ClsJal     = 4'd7,
    ClsJr      = 4'd8,
    ClsHalt    = 4'd9,
    ClsIllegal = 4'd10
  } op_class_e;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode decoder.
// Ports:
//   i_op          opcode IR[31:26]
//   o_cls         instruction class (op_class_e encoding)
//   o_alu_op      ALU function for the execute phase
//   o_alu_src_a   1 = shamt as ALU operand A (sll)
//   o_alu_src_b   1 = extended immediate as ALU operand B
//   o_ext_sel     1 = sign-extend, 0 = zero-extend
//   o_reg_dst     10 = rd (R-type), 01 = rt (I-type / lw)
module op_class_decode
  import mcpu_pkg::*;
(
  input  logic [5:0] i_op,
  output logic [3:0] o_cls,
  output logic [2:0] o_alu_op,
  output logic       o_alu_src_a,
  output logic       o_alu_src_b,
  output logic       o_ext_sel,
  output logic [1:0] o_reg_dst
);

  op_class_e w_cls;

  always_comb begin
    w_cls       = ClsIllegal;
    o_alu_op    = AluAdd;
    o_alu_src_a = 1'b0;
    o_alu_src_b = 1'b0;
    o_ext_sel   = 1'b1;
    o_reg_dst   = 2'b00;
    case (i_op)
      OpAdd:   begin w_cls = ClsAlu; o_alu_op = AluAdd; o_reg_dst = 2'b10; end
      OpSub:   begin w_cls = ClsAlu; o_alu_op = AluSub; o_reg_dst = 2'b10; end
      OpAnd:   begin w_cls = ClsAlu; o_alu_op = AluAnd; o_reg_dst = 2'b10; end
      OpSll: begin
        w_cls       = ClsAlu;
        o_alu_op    = AluSll;
        o_alu_src_a = 1'b1;
        o_reg_dst   = 2'b10;
      end
      OpAddiu: begin
        w_cls = ClsAlu; o_alu_op = AluAdd; o_alu_src_b = 1'b1; o_reg_dst = 2'b01;
      end
      OpAndi: begin
        w_cls = ClsAlu; o_alu_op = AluAnd; o_alu_src_b = 1'b1; o_ext_sel = 1'b0;
        o_reg_dst = 2'b01;
      end
      OpOri: begin
        w_cls = ClsAlu; o_alu_op = AluOr; o_alu_src_b = 1'b1; o_ext_sel = 1'b0;
        o_reg_dst = 2'b01;
      end
      OpXori: begin
        w_cls = ClsAlu; o_alu_op = AluXor; o_alu_src_b = 1'b1; o_ext_sel = 1'b0;
        o_reg_dst = 2'b01;
      end
      OpSlti: begin
        w_cls = ClsAlu; o_alu_op = AluSlt; o_alu_src_b = 1'b1; o_reg_dst = 2'b01;
      end
      OpSw:    begin w_cls = ClsSw; o_alu_src_b = 1'b1; end
      OpLw:    begin w_cls = ClsLw; o_alu_src_b = 1'b1; o_reg_dst = 2'b01; end
      OpBeq:   begin w_cls = ClsBeq;  o_alu_op = AluSub; end
      OpBne:   begin w_cls = ClsBne;  o_alu_op = AluSub; end
      OpBltz:  begin w_cls = ClsBltz; o_alu_op = AluSub; end
      OpJ:     w_cls = ClsJ;
      OpJal:   w_cls = ClsJal;
      OpJr:    w_cls = ClsJr;
      OpHalt:  w_cls = ClsHalt;
      default: w_cls = ClsIllegal;
    endcase
  end

  assign o_cls = w_cls;

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle sequencer for the MIPS datapath. Splits each instruction into
// IF/ID/EXE/MEM/WB states, drives datapath selects and write enables, and
// counts retired instructions (PCWre pulses).
// Ports:
//   CLK, Reset     clock; asynchronous active-high reset
//   Op             IR[31:26]; Zero/Sign ALU flags for branches
//   PCWre..ALUOp   datapath enables and selects (combinational)
//   State          current FSM state; Illegal pulses on an undefined opcode
//   InsCount       retired-instruction count, wraps modulo 2^CNT_W
module multi_cycle_control_unit
  import mcpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       Op,
  input  logic             Zero,
  input  logic             Sign,
  output logic             PCWre,
  output logic             IRWre,
  output logic             InsMemRW,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic             DBDataSrc,
  output logic             RegWre,
  output logic             mRD,
  output logic             mWR,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUOp,
  output logic [3:0]       State,
  output logic             Illegal,
  output logic [CNT_W-1:0] InsCount
);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_ins_count;

  logic [3:0] w_cls_raw;
  op_class_e  w_cls;
  logic [2:0] w_dec_alu_op;
  logic       w_dec_src_a, w_dec_src_b, w_dec_ext;
  logic [1:0] w_dec_reg_dst;

  op_class_decode u_decode (
    .i_op        (Op),
    .o_cls       (w_cls_raw),
    .o_alu_op    (w_dec_alu_op),
    .o_alu_src_a (w_dec_src_a),
    .o_alu_src_b (w_dec_src_b),
    .o_ext_sel   (w_dec_ext),
    .o_reg_dst   (w_dec_reg_dst)
  );

  assign w_cls = op_class_e'(w_cls_raw);

  logic       w_pc_wre, w_ir_wre, w_ins_mem_rw, w_src_a, w_src_b, w_ext_sel;
  logic [1:0] w_reg_dst, w_pc_src;
  logic       w_wr_reg_d_src, w_db_data_src, w_reg_wre, w_m_rd, w_m_wr, w_illegal;
  logic [2:0] w_alu_op;
  logic       w_taken;

  always_comb begin
    unique case (w_cls)
      ClsBeq:  w_taken = Zero;
      ClsBne:  w_taken = ~Zero;
      ClsBltz: w_taken = Sign;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d      = r_state;
    w_pc_wre       = 1'b0;
    w_ir_wre       = 1'b0;
    w_ins_mem_rw   = 1'b0;
    w_src_a        = 1'b0;
    w_src_b        = 1'b0;
    w_ext_sel      = 1'b0;
    w_reg_dst      = 2'b00;
    w_wr_reg_d_src = 1'b0;
    w_db_data_src  = 1'b0;
    w_reg_wre      = 1'b0;
    w_m_rd         = 1'b0;
    w_m_wr         = 1'b0;
    w_pc_src       = 2'b00;
    w_alu_op       = AluAdd;
    w_illegal      = 1'b0;
    case (r_state)
      StIf: begin
        w_ins_mem_rw = 1'b1;
        w_ir_wre     = 1'b1;
        w_state_d    = StId;
      end
      StId: begin
        case (w_cls)
          ClsJ: begin
            w_pc_src = 2'b11; w_pc_wre = 1'b1; w_state_d = StIf;
          end
          ClsJal: begin
            w_pc_src       = 2'b11;
            w_pc_wre       = 1'b1;
            w_reg_wre      = 1'b1;
            w_reg_dst      = 2'b00;
            w_wr_reg_d_src = 1'b0;
            w_state_d      = StIf;
          end
          ClsJr: begin
            w_pc_src = 2'b10; w_pc_wre = 1'b1; w_state_d = StIf;
          end
          ClsHalt:                w_state_d = StHalt;
          ClsBeq, ClsBne, ClsBltz: w_state_d = StExeBr;
          ClsSw, ClsLw:           w_state_d = StExeLs;
          ClsAlu:                 w_state_d = StExeAl;
          default: begin
            // Undefined opcode retires as a nop.
            w_illegal = 1'b1; w_pc_wre = 1'b1; w_state_d = StIf;
          end
        endcase
      end
      StExeAl, StWbAl: begin
        // ALU selects stay stable across both phases so the result holds for WB.
        w_alu_op  = w_dec_alu_op;
        w_src_a   = w_dec_src_a;
        w_src_b   = w_dec_src_b;
        w_ext_sel = w_dec_ext;
        w_reg_dst = w_dec_reg_dst;
        if (r_state == StExeAl) begin
          w_state_d = StWbAl;
        end else begin
          w_reg_wre      = 1'b1;
          w_wr_reg_d_src = 1'b1;
          w_pc_wre       = 1'b1;
          w_state_d      = StIf;
        end
      end
      StExeBr: begin
        w_alu_op  = AluSub;
        w_pc_wre  = 1'b1;
        w_pc_src  = w_taken ? 2'b01 : 2'b00;
        w_state_d = StIf;
      end
      StExeLs, StMem, StWbLd: begin
        // Address computation held through the memory phases.
        w_alu_op  = AluAdd;
        w_src_b   = 1'b1;
        w_ext_sel = 1'b1;
        if (r_state == StExeLs) begin
          w_state_d = StMem;
        end else if (r_state == StMem) begin
          if (w_cls == ClsLw) begin
            w_m_rd    = 1'b1;
            w_state_d = StWbLd;
          end else begin
            w_m_wr    = 1'b1;
            w_pc_wre  = 1'b1;
            w_state_d = StIf;
          end
        end else begin
          w_m_rd         = 1'b1;
          w_db_data_src  = 1'b1;
          w_reg_dst      = 2'b01;
          w_reg_wre      = 1'b1;
          w_wr_reg_d_src = 1'b1;
          w_pc_wre       = 1'b1;
          w_state_d      = StIf;
        end
      end
      StHalt:  w_state_d = StHalt;
      default: w_state_d = StIf;
    endcase
  end

  // Reset gates every output so an in-flight write is dropped immediately.
  always_comb begin
    PCWre     = Reset ? 1'b0 : w_pc_wre;
    IRWre     = Reset ? 1'b0 : w_ir_wre;
    InsMemRW  = Reset ? 1'b0 : w_ins_mem_rw;
    ALUSrcA   = Reset ? 1'b0 : w_src_a;
    ALUSrcB   = Reset ? 1'b0 : w_src_b;
    ExtSel    = Reset ? 1'b0 : w_ext_sel;
    RegDst    = Reset ? 2'b00 : w_reg_dst;
    WrRegDSrc = Reset ? 1'b0 : w_wr_reg_d_src;
    DBDataSrc = Reset ? 1'b0 : w_db_data_src;
    RegWre    = Reset ? 1'b0 : w_reg_wre;
    mRD       = Reset ? 1'b0 : w_m_rd;
    mWR       = Reset ? 1'b0 : w_m_wr;
    PCSrc     = Reset ? 2'b00 : w_pc_src;
    ALUOp     = Reset ? 3'b000 : w_alu_op;
    Illegal   = Reset ? 1'b0 : w_illegal;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state     <= StIf;
      r_ins_count <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_pc_wre) begin
        r_ins_count <= r_ins_count + CNT_W'(1);
      end
    end
  end

  assign State    = r_state;
  assign InsCount = r_ins_count;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: a directed vector table, hand-written
// halt and reset-during-store sequences, and randomized instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_multi_cycle_control_unit;

  localparam int CW = 4;  // small counter so wrap-around is reachable

  logic          CLK, Reset, Zero, Sign;
  logic [5:0]    Op;
  logic          PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel;
  logic [1:0]    RegDst, PCSrc;
  logic          WrRegDSrc, DBDataSrc, RegWre, mRD, mWR, Illegal;
  logic [2:0]    ALUOp;
  logic [3:0]    State;
  logic [CW-1:0] InsCount;

  multi_cycle_control_unit #(.CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .Op(Op), .Zero(Zero), .Sign(Sign),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc), .RegWre(RegWre), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc),
    .ALUOp(ALUOp), .State(State), .Illegal(Illegal), .InsCount(InsCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0, n_err = 0;
  int model_count = 0;
  logic [5:0] cur_op;
  int cur_k;
  int act_lat;
  logic [1:0] act_pcsrc;

  // Instruction classes of the reference model
  localparam int CR = 0, CI = 1, CBEQ = 2, CBNE = 3, CBLTZ = 4, CSW = 5, CLW = 6;
  localparam int CJ = 7, CJAL = 8, CJR = 9, CHALT = 10, CILL = 11;

  function automatic int class_of(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b010000, 6'b011000: return CR;
      6'b000010, 6'b010001, 6'b010010, 6'b010011, 6'b100110: return CI;
      6'b110100: return CBEQ;
      6'b110101: return CBNE;
      6'b110110: return CBLTZ;
      6'b110000: return CSW;
      6'b110001: return CLW;
      6'b111000: return CJ;
      6'b111010: return CJAL;
      6'b111001: return CJR;
      6'b111111: return CHALT;
      default:   return CILL;
    endcase
  endfunction

  function automatic int lat_of(input int c);
    case (c)
      CR, CI, CSW:       return 4;
      CBEQ, CBNE, CBLTZ: return 3;
      CLW:               return 5;
      default:           return 2;
    endcase
  endfunction

  // State number visited in cycle k of an instruction of class c
  function automatic int state_at(input int c, input int k);
    if (k == 0) return 0;
    if (k == 1) return 1;
    case (c)
      CR, CI:            return (k == 2) ? 2 : 3;
      CBEQ, CBNE, CBLTZ: return 4;
      CSW, CLW:          return (k == 2) ? 5 : ((k == 3) ? 6 : 7);
      default:           return 15;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (op %b cycle %0d t=%0t)",
               nm, act, exp, cur_op, cur_k, $time);
    end
  endtask

  task automatic check_cycle(input int c, input int k);
    int  lat;
    logic last, exp_reg, exp_taken;
    logic [1:0] exp_src;
    lat  = lat_of(c);
    last = (k == lat - 1);
    exp_reg = (c == CJAL && k == 1) || ((c == CR || c == CI) && k == 3) || (c == CLW && k == 4);
    chk("State", State, state_at(c, k));
    chk("PCWre", PCWre, last);
    chk("InsMemRW", InsMemRW, k == 0);
    chk("IRWre", IRWre, k == 0);
    chk("RegWre", RegWre, exp_reg);
    chk("mWR", mWR, c == CSW && k == 3);
    chk("mRD", mRD, c == CLW && k >= 3);
    chk("Illegal", Illegal, c == CILL && k == 1);
    chk("InsCount", InsCount, model_count);
    if (PCWre === 1'b1 && act_lat < 0) begin
      act_lat   = k + 1;
      act_pcsrc = PCSrc;
    end
    if (last) begin
      exp_taken = (c == CBEQ && Zero) || (c == CBNE && !Zero) || (c == CBLTZ && Sign);
      case (c)
        CJ, CJAL: exp_src = 2'b11;
        CJR:      exp_src = 2'b10;
        default:  exp_src = exp_taken ? 2'b01 : 2'b00;
      endcase
      chk("PCSrc", PCSrc, exp_src);
    end
    if (exp_reg) begin
      chk("RegDst", RegDst, (c == CJAL) ? 0 : ((c == CR) ? 2 : 1));
      chk("WrRegDSrc", WrRegDSrc, c != CJAL);
    end
    if (c == CLW && k == 4) chk("DBDataSrc", DBDataSrc, 1);
    if ((c == CBEQ || c == CBNE || c == CBLTZ) && k == 2) begin
      chk("ALUOp_br", ALUOp, 3'b001);
      chk("ALUSrcB_br", ALUSrcB, 0);
    end
    if ((c == CSW || c == CLW) && k == 2) begin
      chk("ALUOp_ls", ALUOp, 3'b000);
      chk("ALUSrcB_ls", ALUSrcB, 1);
      chk("ExtSel_ls", ExtSel, 1);
    end
    if ((c == CR || c == CI) && k >= 2) begin
      chk("ALUSrcA", ALUSrcA, cur_op == 6'b011000);
      chk("ALUSrcB_al", ALUSrcB, c == CI);
      if (c == CI)
        chk("ExtSel_al", ExtSel,
            !(cur_op == 6'b010001 || cur_op == 6'b010010 || cur_op == 6'b010011));
    end
  endtask

  // Entered at posedge+1 with the DUT in IF; leaves at posedge+1 after retirement.
  task automatic run_instr(input logic [5:0] op, input logic rnd, input logic z,
                           input logic s);
    int c, lat;
    cur_op  = op;
    Op      = op;
    c       = class_of(op);
    lat     = lat_of(c);
    act_lat = -1;
    act_pcsrc = 2'b00;
    for (int k = 0; k < lat; k++) begin
      cur_k = k;
      if (rnd) begin
        Zero = 1'($urandom_range(1));
        Sign = 1'($urandom_range(1));
      end else begin
        Zero = z;
        Sign = s;
      end
      @(negedge CLK);
      check_cycle(c, k);
      @(posedge CLK);
      #1;
    end
    model_count = (model_count + 1) % (1 << CW);
  endtask

  typedef struct {
    logic [5:0] op;
    logic       zero;
    logic       sign;
    int         lat;
    logic [1:0] pcsrc;
  } vec_t;

  vec_t vecs[21];

  logic [5:0] legal_ops[17];

  initial begin
    vecs[0]  = '{6'b000000, 1'b0, 1'b0, 4, 2'b00};  // add
    vecs[1]  = '{6'b110001, 1'b0, 1'b0, 5, 2'b00};  // lw
    vecs[2]  = '{6'b110100, 1'b1, 1'b0, 3, 2'b01};  // beq taken
    vecs[3]  = '{6'b110100, 1'b0, 1'b0, 3, 2'b00};  // beq not taken
    vecs[4]  = '{6'b110101, 1'b0, 1'b0, 3, 2'b01};  // bne taken
    vecs[5]  = '{6'b110101, 1'b1, 1'b0, 3, 2'b00};  // bne not taken
    vecs[6]  = '{6'b110110, 1'b0, 1'b1, 3, 2'b01};  // bltz taken
    vecs[7]  = '{6'b110110, 1'b1, 1'b0, 3, 2'b00};  // bltz not taken
    vecs[8]  = '{6'b111010, 1'b0, 1'b0, 2, 2'b11};  // jal
    vecs[9]  = '{6'b111000, 1'b0, 1'b0, 2, 2'b11};  // j
    vecs[10] = '{6'b111001, 1'b0, 1'b0, 2, 2'b10};  // jr
    vecs[11] = '{6'b110000, 1'b0, 1'b0, 4, 2'b00};  // sw
    vecs[12] = '{6'b011000, 1'b0, 1'b0, 4, 2'b00};  // sll
    vecs[13] = '{6'b010001, 1'b0, 1'b0, 4, 2'b00};  // andi
    vecs[14] = '{6'b100110, 1'b0, 1'b0, 4, 2'b00};  // slti
    vecs[15] = '{6'b000010, 1'b0, 1'b0, 4, 2'b00};  // addiu
    vecs[16] = '{6'b010010, 1'b0, 1'b0, 4, 2'b00};  // ori
    vecs[17] = '{6'b010011, 1'b0, 1'b0, 4, 2'b00};  // xori
    vecs[18] = '{6'b000001, 1'b0, 1'b0, 4, 2'b00};  // sub
    vecs[19] = '{6'b010000, 1'b0, 1'b0, 4, 2'b00};  // and
    vecs[20] = '{6'b101010, 1'b0, 1'b0, 2, 2'b00};  // undefined
    legal_ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                  6'b010011, 6'b011000, 6'b100110, 6'b110000, 6'b110001, 6'b110100,
                  6'b110101, 6'b110110, 6'b111000, 6'b111001, 6'b111010};

    Reset = 1'b1; Op = 6'b000000; Zero = 1'b0; Sign = 1'b0;
    cur_op = 6'b000000; cur_k = -1;

    // Reset state
    repeat (2) begin
      @(negedge CLK);
      chk("rst_State", State, 0);
      chk("rst_InsMemRW", InsMemRW, 0);
      chk("rst_IRWre", IRWre, 0);
      chk("rst_PCWre", PCWre, 0);
      chk("rst_InsCount", InsCount, 0);
      chk("rst_sel", {RegDst, PCSrc, ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc, DBDataSrc}, 0);
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
    model_count = 0;

    // Directed vector table
    for (int i = 0; i < 21; i++) begin
      run_instr(vecs[i].op, 1'b0, vecs[i].zero, vecs[i].sign);
      chk("latency", act_lat, vecs[i].lat);
      chk("pcsrc_last", act_pcsrc, vecs[i].pcsrc);
    end

    // Halt: ID then parked in HALT with all enables low
    cur_op = 6'b111111; Op = 6'b111111;
    cur_k = 0;
    @(negedge CLK);
    chk("halt_if_State", State, 0);
    chk("halt_if_IRWre", IRWre, 1);
    @(posedge CLK); #1;
    cur_k = 1;
    @(negedge CLK);
    chk("halt_id_State", State, 1);
    chk("halt_id_PCWre", PCWre, 0);
    @(posedge CLK); #1;
    for (int i = 0; i < 20; i++) begin
      cur_k = 2 + i;
      Zero = 1'($urandom_range(1));
      @(negedge CLK);
      chk("halt_State", State, 8);
      chk("halt_PCWre", PCWre, 0);
      chk("halt_en", {RegWre, mWR, mRD, IRWre, InsMemRW, Illegal}, 0);
      chk("halt_InsCount", InsCount, model_count);
      @(posedge CLK); #1;
    end
    Reset = 1'b1;
    #1;
    chk("halt_rst_State", State, 0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    model_count = 0;

    // Randomized instruction stream; wraps the 4-bit counter several times
    for (int i = 0; i < 80; i++) begin
      logic [5:0] op;
      if ($urandom_range(3) == 0) op = 6'($urandom_range(63));
      else op = legal_ops[$urandom_range(16)];
      if (op == 6'b111111) op = 6'b000000;
      run_instr(op, 1'b1, 1'b0, 1'b0);
    end

    // Asynchronous reset during MEM of sw
    cur_op = 6'b110000; Op = 6'b110000; Zero = 1'b0; Sign = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cur_k = k;
      @(negedge CLK);
      check_cycle(CSW, k);
      if (k < 3) begin
        @(posedge CLK); #1;
      end
    end
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_mWR", mWR, 0);
    chk("arst_PCWre", PCWre, 0);
    chk("arst_State", State, 0);
    chk("arst_InsCount", InsCount, 0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    model_count = 0;
    run_instr(6'b000000, 1'b0, 1'b0, 1'b0);
    run_instr(6'b110001, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("final_InsCount", InsCount, model_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
